// File: rtl/seq_shifter_pkg.sv
// Shared encodings for the sequential shift unit.
//   mode_e  : single-step operation selected at start (SRL/SLL/SRA/ROR).
//   state_e : control FSM states (idle, shifting, one-cycle completion).
package seq_shifter_pkg;

    typedef enum logic [1:0] {
        MODE_SRL = 2'b00,
        MODE_SLL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_ROR = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/seq_shifter_if.sv
// Request/response bundle between a controlling FSM and seq_shifter.
//   start, data_in, shamt, mode : request, driven by the master.
//   busy, done, result          : status and working register, driven by the shifter.
interface seq_shifter_if
    import seq_shifter_pkg::*;
#(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
);

    logic               start;
    logic [WIDTH-1:0]   data_in;
    logic [SHAMT_W-1:0] shamt;
    mode_e              mode;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   result;

    modport master (
        output start, data_in, shamt, mode,
        input  busy, done, result
    );

    modport slave (
        input  start, data_in, shamt, mode,
        output busy, done, result
    );

endinterface

// File: rtl/seq_shifter_shift_step.sv
// Combinational single-position shifter.
//   in   : WIDTH-bit operand
//   mode : SRL / SLL / SRA / ROR
//   out  : operand moved by one bit position in the selected direction
// Each output bit is one 4:1 mux over its four candidate sources.
module shift_step
    import seq_shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    output logic [WIDTH-1:0] out,
    input  logic [WIDTH-1:0] in,
    input  mode_e            mode
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic srl_b;
        logic sll_b;
        logic sra_b;
        logic ror_b;

        if (i == WIDTH - 1) begin : g_msb
            assign srl_b = 1'b0;
            assign sra_b = in[WIDTH-1];  // sign replicates
            assign ror_b = in[0];        // LSB wraps around
        end else begin : g_low
            assign srl_b = in[i+1];
            assign sra_b = in[i+1];
            assign ror_b = in[i+1];
        end

        if (i == 0) begin : g_lsb
            assign sll_b = 1'b0;
        end else begin : g_high
            assign sll_b = in[i-1];
        end

        always_comb begin
            unique case (mode)
                MODE_SRL: out[i] = srl_b;
                MODE_SLL: out[i] = sll_b;
                MODE_SRA: out[i] = sra_b;
                MODE_ROR: out[i] = ror_b;
                default:  out[i] = srl_b;
            endcase
        end
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shift unit: shifts a WIDTH-bit operand by shamt positions, one per clock.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; discards any operation in flight
//   bus   : slave side of seq_shifter_if (start/data_in/shamt/mode in,
//           busy/done/result out)
// start is only honoured in ST_IDLE. done pulses for one cycle in ST_DONE; result
// holds its value from then until the next accepted start.
module seq_shifter
    import seq_shifter_pkg::*;
#(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input logic          clk,
    input logic          reset,
    seq_shifter_if.slave bus
);

    state_e             state_q;
    logic [SHAMT_W-1:0] cnt_q;
    mode_e              mode_q;
    logic [WIDTH-1:0]   result_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   step_out;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .out  (step_out),
        .in   (result_q),
        .mode (mode_q)
    );

    // busy/done are registered alongside the state so outputs never see inputs
    // combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mode_q   <= MODE_SRL;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        result_q <= bus.data_in;
                        cnt_q    <= bus.shamt;
                        mode_q   <= bus.mode;
                        busy_q   <= 1'b1;
                        if (bus.shamt == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    result_q <= step_out;
                    cnt_q    <= cnt_q - SHAMT_W'(1);
                    // Leave on the last step so the counter never wraps.
                    if (cnt_q == SHAMT_W'(1)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: doc/seq_shifter.md
Name: seq_shifter

Overview:
- Parametrised, multi-cycle shift unit that shifts a WIDTH-bit operand by a runtime amount, one bit position per clock.
- Supports logical right, logical left, arithmetic right and rotate right.
- Sits beside the sequential multiplier/divider datapath as the general shift resource. Uses a start/busy/done handshake so the controlling FSM can issue a shift and wait for completion.

Parameters:
- WIDTH, 64, operand and result width in bits (>= 2).
- SHAMT_W, $clog2(WIDTH), width of the shift-amount port and internal down-counter.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request. Sampled only in IDLE.
- data_in  input  WIDTH  operand, captured on the accepted start edge.
- shamt  input  SHAMT_W  shift amount 0..WIDTH-1, captured on the accepted start edge.
- mode  input  2  00 SRL, 01 SLL, 10 SRA, 11 ROR. Captured on the accepted start edge.
- busy  output  1  high in SHIFT and DONE states.
- done  output  1  one-cycle completion pulse.
- result  output  WIDTH  working register. Valid when done=1 and held until the next accepted start.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state=IDLE, result=0, counter=0, busy=0, done=0.
  - The captured mode clears to SRL.
  - The operation in flight is discarded. No done pulse is produced.
- IDLE:
  - On a clock edge with start=1: load result<=data_in, cnt<=shamt, latch mode.
  - Next state is SHIFT if shamt!=0, otherwise DONE.
- SHIFT, on each edge:
  - result<=step(result, mode).
  - cnt<=cnt-1.
  - When cnt==1 before the edge, next state is DONE.
- DONE:
  - done=1 and busy=1 for exactly one cycle.
  - Next edge returns to IDLE unconditionally.
- Outputs are decoded from registered state only; no input-to-output combinational paths.
- Latency: done is asserted in the cycle after the (shamt+1)-th edge counted from the start-sampling edge inclusive. shamt=0 therefore gives done one cycle after start; shamt=N gives done N+1 cycles after start.
- Single-step definitions:
  - SRL: {1'b0, r[WIDTH-1:1]}
  - SLL: {r[WIDTH-2:0], 1'b0}
  - SRA: {r[WIDTH-1], r[WIDTH-1:1]}
  - ROR: {r[0], r[WIDTH-1:1]}
- Boundary conditions:
  - start while busy (SHIFT or DONE) is ignored. data_in, shamt and mode changes during busy have no effect.
  - start asserted in the same cycle as done is ignored. The next start is accepted from IDLE, so minimum spacing between starts is shamt+2 cycles.
  - shamt values >= WIDTH (when WIDTH is not a power of two) are not supported and are undefined. Bench must not drive them.
  - The counter never wraps: the SHIFT->DONE exit occurs at cnt==1, and cnt==0 is never entered while in SHIFT.
  - result is unchanged in IDLE and DONE.

Decomposition:
- Package seq_shifter_pkg:
  - Mode encodings: MODE_SRL=2'b00, MODE_SLL=2'b01, MODE_SRA=2'b10, MODE_ROR=2'b11.
  - State encodings: ST_IDLE, ST_SHIFT, ST_DONE (2-bit).
- Sub-module shift_step:
  - Parametrised WIDTH, purely combinational.
  - Ports: (out, in, mode). Implements the four single-step functions with one 4:1 mux per bit.
  - Generalises the existing fixed-width 1-bit right-shift mux chain.
- Top-level holds the FSM, the counter and the result register.

Test Plan:
- SRL, WIDTH=64: data_in=0x8000_0000_0000_0000, shamt=4 -> result=0x0800_0000_0000_0000, done 5 cycles after start, single-cycle pulse.
- SRA, same operand, shamt=4 -> result=0xF800_0000_0000_0000. SRA, data_in=0x4000_0000_0000_0000, shamt=62 -> result=0x1.
- SLL, data_in=0x1, shamt=63 -> 0x8000_0000_0000_0000. ROR, data_in=0x1, shamt=1 -> 0x8000_0000_0000_0000 after 2 cycles.
- shamt=0, data_in=0xDEAD_BEEF_0123_4567, any mode -> result unchanged, done one cycle after start, busy high one cycle.
- Start SRL shamt=10 on 0xFFFF_FFFF_FFFF_FFFF; pulse start with new data at cycles 3 and at done -> both ignored, result=0x003F_FFFF_FFFF_FFFF; the next start is accepted from IDLE.
- Start SLL shamt=20, assert reset asynchronously mid-cycle at cycle 7 -> busy=0, done=0, result=0 immediately. No done pulse follows. A fresh start after reset release completes normally.
